// File: rtl/ex_macrx_if.sv
// ex_macrx_if: byte stream from the PCS receiver, packed words toward the
// receive memory manager, and per-frame status of the slink receive MAC.
`timescale 1ns/1ps

interface ex_macrx_if;
  logic [7:0]  pcsrx_macrx_data;
  logic        pcsrx_macrx_dval;
  logic [17:0] macrx_mmrx_data;
  logic        macrx_mmrx_dval;
  logic        macrx_stat_vld;
  logic        macrx_stat_crc_err;
  logic        macrx_stat_fmt_err;
  logic        slink_rx_eop;

  // MAC side: consumes PCS bytes, produces words and status
  modport master (
    input  pcsrx_macrx_data,
    input  pcsrx_macrx_dval,
    output macrx_mmrx_data,
    output macrx_mmrx_dval,
    output macrx_stat_vld,
    output macrx_stat_crc_err,
    output macrx_stat_fmt_err,
    output slink_rx_eop
  );

  // Environment side: supplies PCS bytes, observes words and status
  modport slave (
    output pcsrx_macrx_data,
    output pcsrx_macrx_dval,
    input  macrx_mmrx_data,
    input  macrx_mmrx_dval,
    input  macrx_stat_vld,
    input  macrx_stat_crc_err,
    input  macrx_stat_fmt_err,
    input  slink_rx_eop
  );
endinterface

// File: rtl/ex_macrx.sv
// ex_macrx: slink receive MAC. Strips the 0x55 preamble and 0xD5 SFD, packs
// payload bytes into {sop,eop,data[15:0]} words, and checks the trailing
// FCS32 (CRC-32, poly 0x04C11DB7, MSB-first, all-ones seed, inverted result,
// sent MSB byte first) and the 0xFD terminator. The last five bytes of every
// frame are held back in a shift line so that only true payload reaches the
// CRC and the packer; a completed word is held one pair so the final word
// can be tagged eop when dval drops.
`timescale 1ns/1ps

module ex_macrx #(
  parameter int MAX_BYTES = 512,
  parameter int PRE_LEN   = 7
) (
  input logic        clk_12_5m,
  input logic        rst_12_5m,
  ex_macrx_if.master bus
);

  localparam int CW = $clog2(MAX_BYTES + 2);
  localparam int PW = $clog2(PRE_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
  localparam logic [CW-1:0] MIN_CNT = CW'(2);
  localparam logic [PW-1:0] PRE_CNT = PW'(PRE_LEN);

  typedef enum logic [2:0] {IDLE, PRE, DATA, DONE, DROP} state_t;

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [39:0]   line;
  logic [2:0]    fill;
  logic [CW-1:0] pay_cnt;
  logic [7:0]    pack_hi;
  logic [15:0]   hold_data;
  logic          hold_vld;
  logic          any_written;
  logic          drop_from_data;
  logic [31:0]   crc;

  logic [7:0]    rx_byte;
  logic          rx_dval;
  logic [7:0]    pop_byte;
  logic [31:0]   crc_next;

  // One byte of the MSB-first CRC-32 update
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign rx_byte  = bus.pcsrx_macrx_data;
  assign rx_dval  = bus.pcsrx_macrx_dval;
  assign pop_byte = line[39:32];
  assign crc_next = crc32_byte(crc, pop_byte);

  // Frame FSM with all datapath state and registered outputs
  always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
    if (!rst_12_5m) begin
      state                  <= IDLE;
      pre_cnt                <= '0;
      line                   <= '0;
      fill                   <= '0;
      pay_cnt                <= '0;
      pack_hi                <= '0;
      hold_data              <= '0;
      hold_vld               <= 1'b0;
      any_written            <= 1'b0;
      drop_from_data         <= 1'b0;
      crc                    <= '0;
      bus.macrx_mmrx_data    <= '0;
      bus.macrx_mmrx_dval    <= 1'b0;
      bus.macrx_stat_vld     <= 1'b0;
      bus.macrx_stat_crc_err <= 1'b0;
      bus.macrx_stat_fmt_err <= 1'b0;
      bus.slink_rx_eop       <= 1'b0;
    end else begin
      bus.macrx_mmrx_dval <= 1'b0;
      bus.macrx_stat_vld  <= 1'b0;
      bus.slink_rx_eop    <= bus.macrx_mmrx_dval & bus.macrx_mmrx_data[16];

      case (state)
        IDLE: begin
          crc            <= '1;
          line           <= '0;
          fill           <= '0;
          pay_cnt        <= '0;
          hold_vld       <= 1'b0;
          any_written    <= 1'b0;
          drop_from_data <= 1'b0;
          pre_cnt        <= '0;
          if (rx_dval) begin
            if (rx_byte == 8'h55) begin
              state   <= PRE;
              pre_cnt <= PW'(1);
            end else begin
              state <= DROP;
            end
          end
        end

        PRE: begin
          if (!rx_dval) begin
            state <= IDLE;
          end else if (rx_byte == 8'h55) begin
            if (pre_cnt == PRE_CNT) state <= DROP;
            else                    pre_cnt <= pre_cnt + PW'(1);
          end else if (rx_byte == 8'hD5 && pre_cnt == PRE_CNT) begin
            state <= DATA;
          end else begin
            state <= DROP;
          end
        end

        DATA: begin
          if (!rx_dval) begin
            state <= DONE;
            if (hold_vld) begin
              bus.macrx_mmrx_data <= {~any_written, 1'b1, hold_data};
              bus.macrx_mmrx_dval <= 1'b1;
              any_written         <= 1'b1;
            end
            hold_vld <= 1'b0;
          end else begin
            line <= {line[31:0], rx_byte};
            if (fill != 3'd5) begin
              fill <= fill + 3'd1;
            end else if (pay_cnt == MAX_CNT) begin
              state          <= DROP;
              drop_from_data <= 1'b1;
              hold_vld       <= 1'b0;
              pay_cnt        <= pay_cnt + CW'(1);
            end else begin
              crc     <= crc_next;
              pay_cnt <= pay_cnt + CW'(1);
              if (!pay_cnt[0]) begin
                pack_hi <= pop_byte;
              end else begin
                if (hold_vld) begin
                  bus.macrx_mmrx_data <= {~any_written, 1'b0, hold_data};
                  bus.macrx_mmrx_dval <= 1'b1;
                  any_written         <= 1'b1;
                end
                hold_data <= {pack_hi, pop_byte};
                hold_vld  <= 1'b1;
              end
            end
          end
        end

        DONE: begin
          state              <= IDLE;
          bus.macrx_stat_vld <= 1'b1;
          if (drop_from_data) begin
            bus.macrx_stat_fmt_err <= 1'b1;
            bus.macrx_stat_crc_err <= 1'b0;
          end else begin
            bus.macrx_stat_fmt_err <= (line[7:0] != 8'hFD) | pay_cnt[0] |
                                      (pay_cnt < MIN_CNT) | (fill != 3'd5);
            bus.macrx_stat_crc_err <= (line[39:8] != ~crc);
          end
        end

        DROP: begin
          if (!rx_dval) begin
            if (drop_from_data) begin
              state               <= DONE;
              bus.macrx_mmrx_data <= {~any_written, 1'b1, 16'h0000};
              bus.macrx_mmrx_dval <= 1'b1;
              any_written         <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_macrx.sv
// tb_ex_macrx: directed and randomized frames checked against a frame-level
// reference model of the slink receive MAC.
`timescale 1ns/1ps

module tb_ex_macrx;
  localparam int MAX_BYTES = 512;
  localparam int PRE_LEN   = 7;

  typedef logic [7:0] bq_t[$];

  logic clk_12_5m = 1'b0;
  logic rst_12_5m = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [17:0] got_w[$];
  logic [17:0] exp_w[$];
  int          got_eop[$];
  int          exp_eop[$];
  int          got_slink[$];
  int          got_st[$];
  int          exp_st[$];
  logic [1:0]  got_fl[$];
  logic [1:0]  exp_fl[$];

  ex_macrx_if bus();

  ex_macrx #(.MAX_BYTES(MAX_BYTES), .PRE_LEN(PRE_LEN)) dut (
    .clk_12_5m(clk_12_5m),
    .rst_12_5m(rst_12_5m),
    .bus(bus)
  );

  // 12.5 MHz clock
  always #40 clk_12_5m = ~clk_12_5m;

  // Cycle counter used to time-stamp observed events
  always @(posedge clk_12_5m) cyc <= cyc + 1;

  // Output monitor, sampled on the inactive edge
  always @(negedge clk_12_5m) begin
    if (rst_12_5m) begin
      if (bus.macrx_mmrx_dval) begin
        got_w.push_back(bus.macrx_mmrx_data);
        if (bus.macrx_mmrx_data[16]) got_eop.push_back(cyc);
      end
      if (bus.macrx_stat_vld) begin
        got_st.push_back(cyc);
        got_fl.push_back({bus.macrx_stat_crc_err, bus.macrx_stat_fmt_err});
      end
      if (bus.slink_rx_eop) got_slink.push_back(cyc);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fcs(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[k]) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = c[31] ^ d[k][b];
        c  = c << 1;
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    return ~c;
  endfunction

  function automatic bq_t rand_pay(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255, 0)));
    return q;
  endfunction

  // Wire frame: preamble (optionally corrupted), SFD, payload, FCS, terminator
  function automatic bq_t make_frame(input bq_t pay, input int npre, input logic [7:0] pre_sub,
                                     input logic [31:0] fcs_flip, input logic [7:0] term);
    bq_t q;
    logic [31:0] f;
    for (int i = 0; i < npre; i++) q.push_back((i == 2) ? pre_sub : 8'h55);
    q.push_back(8'hD5);
    foreach (pay[i]) q.push_back(pay[i]);
    f = ref_fcs(pay) ^ fcs_flip;
    q.push_back(f[31:24]);
    q.push_back(f[23:16]);
    q.push_back(f[15:8]);
    q.push_back(f[7:0]);
    q.push_back(term);
    return q;
  endfunction

  // Reference model: expected words and status of one wire frame
  task automatic expect_frame(input bq_t fr, input int t0);
    int          base;
    int          n;
    int          np;
    bit          ok;
    bq_t         pay;
    logic [31:0] fcs;
    logic [7:0]  term;
    base = PRE_LEN + 1;
    ok = (fr.size() >= base + 5);
    for (int i = 0; i < PRE_LEN && ok; i++) ok = (fr[i] == 8'h55);
    if (ok) ok = (fr[PRE_LEN] == 8'hD5);
    if (!ok) return;
    n = fr.size() - base - 5;
    if (n > MAX_BYTES) begin
      np = MAX_BYTES / 2 - 1;
      for (int p = 0; p < np; p++)
        exp_w.push_back({(p == 0), 1'b0, fr[base + 2*p], fr[base + 2*p + 1]});
      exp_w.push_back({(np == 0), 1'b1, 16'h0000});
      exp_eop.push_back(t0 + 1);
      exp_st.push_back(t0 + 2);
      exp_fl.push_back(2'b01);
    end else begin
      for (int i = 0; i < n; i++) pay.push_back(fr[base + i]);
      fcs  = {fr[base + n], fr[base + n + 1], fr[base + n + 2], fr[base + n + 3]};
      term = fr[base + n + 4];
      np = n / 2;
      for (int p = 0; p < np; p++)
        exp_w.push_back({(p == 0), (p == np - 1), pay[2*p], pay[2*p + 1]});
      if (np > 0) exp_eop.push_back(t0 + 1);
      exp_st.push_back(t0 + 2);
      exp_fl.push_back({(fcs != ref_fcs(pay)), ((term != 8'hFD) || (n % 2 != 0) || (n < 2))});
    end
  endtask

  task automatic apply_stimulus(input bq_t fr, input int ipg);
    int t0;
    foreach (fr[i]) begin
      @(negedge clk_12_5m);
      bus.pcsrx_macrx_data = fr[i];
      bus.pcsrx_macrx_dval = 1'b1;
    end
    @(negedge clk_12_5m);
    bus.pcsrx_macrx_data = 8'h00;
    bus.pcsrx_macrx_dval = 1'b0;
    t0 = cyc;
    expect_frame(fr, t0);
    repeat (ipg - 1) @(negedge clk_12_5m);
  endtask

  function automatic logic [31:0] pick_w(input int i);
    return (i < got_w.size()) ? 32'(got_w[i]) : 32'hFFFF_FFFF;
  endfunction

  // Compare everything observed since the last call against the model
  task automatic check_all(input string name);
    check_output({name, "_nwords"}, got_w.size(), exp_w.size());
    foreach (exp_w[i]) check_output($sformatf("%s_w%0d", name, i), pick_w(i), exp_w[i]);
    check_output({name, "_neop"}, got_eop.size(), exp_eop.size());
    check_output({name, "_nslink"}, got_slink.size(), exp_eop.size());
    foreach (exp_eop[i]) begin
      check_output($sformatf("%s_eopcyc%0d", name, i),
                   (i < got_eop.size()) ? got_eop[i] : -1, exp_eop[i]);
      check_output($sformatf("%s_slinkcyc%0d", name, i),
                   (i < got_slink.size()) ? got_slink[i] : -1, exp_eop[i] + 1);
    end
    check_output({name, "_nstat"}, got_st.size(), exp_st.size());
    foreach (exp_st[i]) begin
      check_output($sformatf("%s_statcyc%0d", name, i),
                   (i < got_st.size()) ? got_st[i] : -1, exp_st[i]);
      check_output($sformatf("%s_statflags%0d", name, i),
                   (i < got_fl.size()) ? 32'(got_fl[i]) : 32'hF, 32'(exp_fl[i]));
    end
    got_w.delete(); exp_w.delete(); got_eop.delete(); exp_eop.delete();
    got_slink.delete(); got_st.delete(); exp_st.delete(); got_fl.delete(); exp_fl.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    check_output({name, "_data"}, bus.macrx_mmrx_data, 0);
    check_output({name, "_dval"}, bus.macrx_mmrx_dval, 0);
    check_output({name, "_stat"}, bus.macrx_stat_vld, 0);
    check_output({name, "_crc"}, bus.macrx_stat_crc_err, 0);
    check_output({name, "_fmt"}, bus.macrx_stat_fmt_err, 0);
    check_output({name, "_eop"}, bus.slink_rx_eop, 0);
  endtask

  // Directed test sequence
  initial begin
    bq_t pay;
    bq_t fr;
    bus.pcsrx_macrx_data = 8'h00;
    bus.pcsrx_macrx_dval = 1'b0;

    repeat (3) @(negedge clk_12_5m);
    check_zero_outputs("reset");
    rst_12_5m = 1'b1;
    repeat (2) @(negedge clk_12_5m);

    $display("[TB] good frame");
    pay = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    apply_stimulus(make_frame(pay, PRE_LEN, 8'h55, 32'h0, 8'hFD), 4);
    repeat (3) @(negedge clk_12_5m);
    check_output("good_lit0", pick_w(0), 32'h21234);
    check_output("good_lit1", pick_w(1), 32'h0ABCD);
    check_output("good_lit2", pick_w(2), 32'h10001);
    check_all("good");

    $display("[TB] minimal frame");
    pay = '{8'hA5, 8'h5A};
    apply_stimulus(make_frame(pay, PRE_LEN, 8'h55, 32'h0, 8'hFD), 4);
    repeat (3) @(negedge clk_12_5m);
    check_output("min_lit0", pick_w(0), 32'h3A55A);
    check_all("min");

    $display("[TB] corrupt FCS");
    pay = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    apply_stimulus(make_frame(pay, PRE_LEN, 8'h55, 32'h0000_0004, 8'hFD), 4);
    repeat (3) @(negedge clk_12_5m);
    check_output("crc_held", bus.macrx_stat_crc_err, 1);
    check_all("crcbad");

    $display("[TB] preamble faults");
    apply_stimulus(make_frame(rand_pay(8), PRE_LEN - 1, 8'h55, 32'h0, 8'hFD), 2);
    apply_stimulus(make_frame(rand_pay(8), PRE_LEN + 1, 8'h55, 32'h0, 8'hFD), 2);
    apply_stimulus(make_frame(rand_pay(8), PRE_LEN, 8'h54, 32'h0, 8'hFD), 2);
    apply_stimulus(make_frame(rand_pay(10), PRE_LEN, 8'h55, 32'h0, 8'hFD), 4);
    repeat (3) @(negedge clk_12_5m);
    check_all("preamble");

    $display("[TB] format faults");
    apply_stimulus(make_frame(rand_pay(6), PRE_LEN, 8'h55, 32'h0, 8'hFE), 3);
    apply_stimulus(make_frame(rand_pay(3), PRE_LEN, 8'h55, 32'h0, 8'hFD), 3);
    apply_stimulus(make_frame(rand_pay(MAX_BYTES + 2), PRE_LEN, 8'h55, 32'h0, 8'hFD), 3);
    apply_stimulus(make_frame(rand_pay(MAX_BYTES), PRE_LEN, 8'h55, 32'h0, 8'hFD), 4);
    repeat (3) @(negedge clk_12_5m);
    check_all("format");

    $display("[TB] random back-to-back frames");
    for (int k = 0; k < 8; k++) begin
      logic [31:0] flip;
      flip = ($urandom_range(3, 0) == 0) ? (32'h1 << $urandom_range(31, 0)) : 32'h0;
      apply_stimulus(make_frame(rand_pay(2 * $urandom_range(20, 1)), PRE_LEN, 8'h55, flip, 8'hFD), 2);
    end
    repeat (4) @(negedge clk_12_5m);
    check_all("b2b");

    $display("[TB] reset mid-payload");
    fr = make_frame(rand_pay(40), PRE_LEN, 8'h55, 32'h0, 8'hFD);
    for (int i = 0; i < PRE_LEN + 1 + 20; i++) begin
      @(negedge clk_12_5m);
      bus.pcsrx_macrx_data = fr[i];
      bus.pcsrx_macrx_dval = 1'b1;
    end
    @(negedge clk_12_5m);
    rst_12_5m = 1'b0;
    #1;
    check_zero_outputs("midrst");
    bus.pcsrx_macrx_dval = 1'b0;
    bus.pcsrx_macrx_data = 8'h00;
    repeat (2) @(negedge clk_12_5m);
    check_zero_outputs("inrst");
    rst_12_5m = 1'b1;
    repeat (6) @(negedge clk_12_5m);
    check_output("abort_eop", got_eop.size(), 0);
    check_output("abort_stat", got_st.size(), 0);
    got_w.delete(); got_eop.delete(); got_slink.delete(); got_st.delete(); got_fl.delete();
    apply_stimulus(make_frame(rand_pay(16), PRE_LEN, 8'h55, 32'h0, 8'hFD), 4);
    repeat (3) @(negedge clk_12_5m);
    check_all("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_macrx.md
Name: ex_macrx

Overview:
Receive-side MAC for the slink serial link, the counterpart of the slink transmit MAC. It takes the byte stream from the PCS receiver, strips the 0x55×7/0xD5 preamble, and packs payload bytes into 18-bit {sop,eop,data} words for the receive memory manager. It also strips and checks the trailing 4-byte FCS32 and the 0xFD terminator, and reports per-frame status.

Parameters:
MAX_BYTES, 512, maximum payload bytes per frame (header included); must be even.
PRE_LEN, 7, number of 0x55 preamble bytes before the 0xD5 SFD.

Ports:
clk_12_5m  input  1  system clock, 12.5 MHz
rst_12_5m  input  1  reset; asynchronous assert, active-low (0 = reset)
pcsrx_macrx_data  input  8  received byte from the PCS
pcsrx_macrx_dval  input  1  byte valid; high for the whole frame, low during IPG
macrx_mmrx_data  output  18  [17]=sop, [16]=eop, [15:8]=first byte, [7:0]=second byte
macrx_mmrx_dval  output  1  word valid, one-cycle pulse per word
macrx_stat_vld  output  1  one-cycle pulse, frame status valid
macrx_stat_crc_err  output  1  FCS mismatch (qualified by stat_vld)
macrx_stat_fmt_err  output  1  bad terminator, odd length or too long (qualified by stat_vld)
slink_rx_eop  output  1  one-cycle pulse, registered copy of the eop word strobe

Behaviour:
- Frame on the wire, with dval continuously high: PRE_LEN×0x55, 0xD5, N payload bytes (N even, 2 ≤ N ≤ MAX_BYTES; the first 2 bytes are the packet header), 4 FCS bytes MSB-first, 0xFD. dval then stays low for at least 2 cycles.
- Reset values: all outputs 0; FSM in IDLE; the shift line, byte counter, pack register and CRC state are all cleared.
- The FSM has 5 states: IDLE, PRE, DATA, DONE, DROP.
- IDLE:
  - dval=1 and byte=0x55 → PRE, with pre_cnt=1.
  - dval=1 and any other byte → DROP.
- PRE:
  - 0x55 increments pre_cnt.
  - 0xD5 with pre_cnt==PRE_LEN → DATA.
  - 0xD5 with any other count, any other byte, or more than PRE_LEN 0x55 bytes → DROP.
  - dval=0 → IDLE.
  - In every one of these cases no output and no status is produced.
- DATA:
  - Every byte with dval=1 enters a 5-byte shift line. A byte leaving the line (the 6th and later bytes) is payload.
  - Each payload byte feeds the FCS32 instance (the same CRC as the transmit side) and the pack register. Even-indexed bytes go to [15:8]; odd-indexed bytes go to [7:0].
  - A completed pair is held one cycle, not written. When the next pair completes, the held word is written with dval=1. The first word written has sop=1.
  - A payload count exceeding MAX_BYTES sets fmt_err, and the FSM moves to DROP, which still ends in a status pulse.
  - dval=0 → DONE.
- DONE (one cycle):
  - The shift line holds FCS[31:0] followed by 0xFD.
  - fmt_err is set if the terminator ≠ 0xFD or the payload count is odd or less than 2.
  - crc_err is set if FCS32 ≠ the received FCS.
  - If at least one word is held, it is written with eop=1, and with sop=1 as well if it is the only word.
  - The FSM then goes to IDLE.
- Status timing:
  - macrx_stat_vld pulses the cycle after the eop word.
  - The error flags are valid with stat_vld and hold until the next stat_vld.
  - If fmt_err is set with no word ever written, the status pulse is still issued and no eop is sent.
- Latency: the eop word appears on the cycle after the first dval=0 sample. slink_rx_eop follows 1 cycle after that.
- DROP: ignore bytes until dval=0, then go to IDLE. If DROP was entered from DATA, issue a status pulse with fmt_err=1 and an eop word carrying data 0x0000.
- FCS32 state reinitialises in IDLE. At most one macrx_mmrx_dval occurs per 2 input bytes, so no backpressure exists and none is provided.
- dval reasserting in the cycle right after DONE is legal: IDLE samples that byte.
- Reset mid-frame: all state clears immediately; no eop and no status is emitted for the aborted frame.

Test Plan:
- Good frame: 7×55, D5, payload 12 34 AB CD 00 01, valid FCS, FD → 3 words 0x21234, 0x0ABCD, 0x10001; stat_vld with crc_err=0, fmt_err=0; slink_rx_eop 1 cycle after the eop word.
- Minimal frame: payload 0xA5 0x5A → single word 0x3A55A; status clean.
- Corrupt FCS: flip one bit of the last FCS byte of scenario 1 → same 3 words; stat crc_err=1, fmt_err=0.
- Preamble faults: 6×55+D5, 8×55+D5, and 0x54 in the preamble → no mmrx_dval, no stat_vld. A following good frame is received correctly.
- Format faults:
  - Terminator 0xFE → fmt_err=1.
  - Odd payload of 3 bytes → fmt_err=1.
  - MAX_BYTES+2 payload → fmt_err=1, eop word with data 0x0000, stat_vld once.
- Back-to-back frames separated by a 2-cycle IPG, plus reset asserted mid-payload → frame words stay correct; the aborted frame produces no eop and no status, and all outputs read 0 during reset.
